// File: rtl/reg_reader_pkg.sv
// Shared definitions for the burst register reader: FSM state encoding and register count.
package reg_reader_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSetup   = 2'd1,
      StCapture = 2'd2,
      StSend    = 2'd3
   } state_e;

   localparam int unsigned REG_COUNT = 8;

endpackage

// File: rtl/reg_reader.sv
// Burst reader: fetches register pairs through two async read ports and streams them
// one word at a time over a valid/ready interface.
module reg_reader
   import reg_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] FIRST_ADDR,
   input  logic [ADDR_WIDTH:0]   COUNT,
   output logic [ADDR_WIDTH-1:0] RADDR1,
   output logic [ADDR_WIDTH-1:0] RADDR2,
   input  logic [DATA_WIDTH-1:0] RDATA1,
   input  logic [DATA_WIDTH-1:0] RDATA2,
   output logic [DATA_WIDTH-1:0] DATA,
   output logic                  VALID,
   input  logic                  READY,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int unsigned CntW = ADDR_WIDTH + 1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] raddr1_q, raddr1_d;
   logic [ADDR_WIDTH-1:0] raddr2_q, raddr2_d;
   logic [CntW-1:0]       remain_q, remain_d;
   logic                  sel_q, sel_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [ADDR_WIDTH-1:0] next_ptr;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      raddr1_d = raddr1_q;
      raddr2_d = raddr2_q;
      remain_d = remain_q;
      sel_d    = sel_q;
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      done_d   = 1'b0;
      next_ptr = ptr_q + ADDR_WIDTH'(2);

      unique case (state_q)
         StIdle: begin
            if (START && (COUNT != '0)) begin
               ptr_d    = FIRST_ADDR;
               remain_d = (COUNT > CntW'(REG_COUNT)) ? CntW'(REG_COUNT) : COUNT;
               // Addresses are registered here so they are stable for the whole SETUP cycle.
               raddr1_d = FIRST_ADDR;
               raddr2_d = FIRST_ADDR + ADDR_WIDTH'(1);
               state_d  = StSetup;
            end
         end
         StSetup: begin
            state_d = StCapture;
         end
         StCapture: begin
            buf0_d  = RDATA1;
            buf1_d  = RDATA2;
            sel_d   = 1'b0;
            state_d = StSend;
         end
         StSend: begin
            if (READY) begin
               remain_d = remain_q - CntW'(1);
               if (remain_q == CntW'(1)) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else if (!sel_q) begin
                  sel_d = 1'b1;
               end else begin
                  ptr_d    = next_ptr;
                  raddr1_d = next_ptr;
                  raddr2_d = next_ptr + ADDR_WIDTH'(1);
                  state_d  = StSetup;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         remain_q <= '0;
         sel_q    <= 1'b0;
         done_q   <= 1'b0;
         buf0_q   <= '0;
         buf1_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         raddr1_q <= raddr1_d;
         raddr2_q <= raddr2_d;
         remain_q <= remain_d;
         sel_q    <= sel_d;
         done_q   <= done_d;
         buf0_q   <= buf0_d;
         buf1_q   <= buf1_d;
      end
   end

   always_comb begin
      VALID  = (state_q == StSend);
      BUSY   = (state_q != StIdle);
      DONE   = done_q;
      RADDR1 = raddr1_q;
      RADDR2 = raddr2_q;
      DATA   = VALID ? (sel_q ? buf1_q : buf0_q) : '0;
   end

endmodule

// File: tb/tb_reg_reader.sv
// Self-checking bench for reg_reader: table-driven bursts, a mid-burst reset and random bursts
// checked against a queue-based model of the expected word stream.
module tb_reg_reader;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [2:0] FIRST_ADDR;
   logic [3:0] COUNT;
   logic [2:0] RADDR1, RADDR2;
   logic [7:0] RDATA1, RDATA2;
   logic [7:0] DATA;
   logic       VALID;
   logic       READY;
   logic       BUSY;
   logic       DONE;

   logic [7:0] rf [8];

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   assign RDATA1 = rf[RADDR1];
   assign RDATA2 = rf[RADDR2];

   reg_reader #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .FIRST_ADDR(FIRST_ADDR),
      .COUNT     (COUNT),
      .RADDR1    (RADDR1),
      .RADDR2    (RADDR2),
      .RDATA1    (RDATA1),
      .RDATA2    (RDATA2),
      .DATA      (DATA),
      .VALID     (VALID),
      .READY     (READY),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // mode 0: READY always high; 1: READY low for 4 cycles from first VALID; 2: random READY
   task automatic run_burst(input logic [2:0] first, input logic [3:0] cnt, input int mode,
                            input string tag);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int         acc_q[$];
      int         n, first_v, done_cyc, done_cnt, viol, busy_seen, busy_after;
      logic       v, r, pv, pr;
      logic [7:0] d, pd;
      n = (cnt > 4'd8) ? 8 : int'(cnt);
      for (int i = 0; i < n; i++) exp_q.push_back(rf[3'((int'(first) + i) % 8)]);
      first_v = -1; done_cyc = -1; done_cnt = 0; viol = 0; busy_seen = 0; busy_after = 1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      @(negedge CLK);
      START = 1'b1; FIRST_ADDR = first; COUNT = cnt; READY = (mode == 0);
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge CLK);
         v = VALID; d = DATA;
         if (DONE) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (BUSY || v) busy_seen = 1;
         if (pv && !pr && (!v || d !== pd)) viol++;
         if (v && first_v < 0) first_v = cyc;
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            busy_after = int'(BUSY);
            break;
         end
         if (n == 0 && cyc >= 8) break;
         case (mode)
            0:       r = 1'b1;
            1:       r = (first_v >= 0 && cyc < first_v + 4) ? 1'b0 : 1'b1;
            default: r = 1'($urandom_range(0, 1));
         endcase
         READY = r;
         // Noise on the request inputs while busy must not disturb the running burst.
         START      = BUSY ? 1'($urandom_range(0, 1)) : 1'b0;
         FIRST_ADDR = 3'($urandom);
         COUNT      = 4'($urandom);
         if (v && r) begin
            got_q.push_back(d);
            acc_q.push_back(cyc);
         end
         pv = v; pr = r; pd = d;
      end
      START = 1'b0; READY = 1'b0;
      check({tag, " words"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         check($sformatf("%s word%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
      check({tag, " done_count"}, done_cnt, (n > 0) ? 1 : 0);
      check({tag, " data_stable"}, viol, 0);
      if (n == 0) begin
         check({tag, " idle_no_busy"}, busy_seen, 0);
      end else begin
         check({tag, " latency"}, first_v, 3);
         check({tag, " busy_after_done"}, busy_after, 0);
         if (got_q.size() == n) check({tag, " done_timing"}, done_cyc, acc_q[n-1] + 1);
         if (mode != 2 && got_q.size() == n) begin
            // Second word of a pair follows its first with no bubble; pairs cost 2 bubbles.
            for (int i = 1; i < n; i++)
               check($sformatf("%s gap%0d", tag, i), acc_q[i] - acc_q[i-1],
                     (i % 2 == 1) ? 1 : 3);
         end
      end
   endtask

   typedef struct {
      logic [2:0] first;
      logic [3:0] cnt;
      int         mode;
   } vec_t;

   initial begin
      vec_t vecs[8];
      int   found;
      int   seen;
      int   done_bad;
      vecs[0] = '{3'd0, 4'd8,  0};
      vecs[1] = '{3'd6, 4'd3,  0};
      vecs[2] = '{3'd2, 4'd2,  1};
      vecs[3] = '{3'd0, 4'd0,  0};
      vecs[4] = '{3'd3, 4'd12, 0};
      vecs[5] = '{3'd7, 4'd5,  0};
      vecs[6] = '{3'd5, 4'd1,  1};
      vecs[7] = '{3'd1, 4'd15, 2};

      for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
      RESET = 1'b0; START = 1'b0; FIRST_ADDR = '0; COUNT = '0; READY = 1'b0;
      #3;
      check("reset valid", int'(VALID), 0);
      check("reset busy", int'(BUSY), 0);
      check("reset done", int'(DONE), 0);
      check("reset data", int'(DATA), 0);
      check("reset raddr1", int'(RADDR1), 0);
      check("reset raddr2", int'(RADDR2), 0);
      @(negedge CLK);
      RESET = 1'b1;

      for (int i = 0; i < 8; i++) run_burst(vecs[i].first, vecs[i].cnt, vecs[i].mode,
                                            $sformatf("vec%0d", i));

      // Reset while the second word of a burst is on offer.
      @(negedge CLK);
      START = 1'b1; FIRST_ADDR = 3'd0; COUNT = 4'd4; READY = 1'b1;
      found = 0; seen = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge CLK);
         START = 1'b0;
         if (VALID) begin
            seen++;
            if (seen == 2) begin
               check("rst word1", int'(DATA), 8'h11);
               found = 1;
               break;
            end
         end
      end
      check("rst reached_word1", found, 1);
      READY = 1'b0;
      #2 RESET = 1'b0;
      #1;
      check("rst valid", int'(VALID), 0);
      check("rst busy", int'(BUSY), 0);
      check("rst data", int'(DATA), 0);
      check("rst raddr1", int'(RADDR1), 0);
      done_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (DONE || VALID || BUSY) done_bad++;
      end
      RESET = 1'b1;
      check("rst quiet", done_bad, 0);
      run_burst(3'd4, 4'd4, 0, "after_rst");

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
         run_burst(3'($urandom), 4'($urandom_range(0, 15)), 2, $sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
